run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter RUN_LEN, default 2, consecutive matching samples required for detection (1..255).
REQ-003 SHALL have parameter HIT_W, default 16, width of each per-channel hit counter.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear of all channel state and hit counters.
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel sample-valid strobe.
REQ-008 SHALL have port in_bit  input  CHANNELS  per-channel sample value.
REQ-009 SHALL have port match_val  input  1  bit value being detected (1 = runs of ones, 0 = runs of zeros), shared by all channels.
REQ-010 SHALL have port overlap  input  1  1 = detection held while run continues; 0 = counting restarts after each detection.
REQ-011 SHALL have port det  output  CHANNELS  per-channel Moore detect flag.
REQ-012 SHALL have port det_pulse  output  CHANNELS  one-cycle pulse on each entry into DETECTED.
REQ-013 SHALL have port hit_cnt  output  CHANNELS*HIT_W  packed per-channel hit counters, channel 0 in LSBs.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, COUNT, DETECTED and a run counter of width clog2(RUN_LEN+1).
REQ-015 A sample SHALL be consumed only in a cycle with in_valid[i]=1; with in_valid[i]=0 the channel state, counter and det[i] SHALL hold.
REQ-016 On a consumed mismatching sample (in_bit != match_val), the channel SHALL go to IDLE with counter 0, from any state.
REQ-017 On a consumed matching sample in IDLE/COUNT, the counter SHALL increment; when it reaches RUN_LEN the state SHALL become DETECTED, else COUNT.
REQ-018 On a consumed matching sample in DETECTED with overlap=1, the channel SHALL remain DETECTED with no new det_pulse.
REQ-019 On a consumed matching sample in DETECTED with overlap=0, the counter SHALL restart at 1 and the state SHALL be COUNT, or re-enter DETECTED with a new det_pulse if RUN_LEN=1.
REQ-020 det[i] SHALL equal (state==DETECTED), registered; it SHALL assert in the cycle after the clock edge consuming the RUN_LEN-th matching sample (latency 1).
REQ-021 det_pulse[i] SHALL be high for exactly one cycle per transition into DETECTED, aligned with the first cycle det[i] is high.
REQ-022 Changes to match_val or overlap SHALL take effect on the next consumed sample without clearing existing counters.
REQ-023 clr=1 SHALL force every channel to IDLE, counter 0, hit_cnt 0 at the next edge, taking priority over in_valid.
REQ-024 Counters SHALL never exceed RUN_LEN; no wrap-around of the run counter SHALL occur.

Reset
REQ-025 While rst=1, all channels SHALL be IDLE with counter 0, and det, det_pulse and hit_cnt SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-run SHALL discard partial runs; the first matching sample after release SHALL count as 1.

Configuration
REQ-027 With RUN_DET_HITCNT_EN defined, hit_cnt[i] SHALL increment on each det_pulse[i] and saturate at 2^HIT_W-1.
REQ-028 Without RUN_DET_HITCNT_EN, hit_cnt SHALL be tied to 0, no counter logic SHALL be present, and the port SHALL remain.

Structure
REQ-029 Package run_det_pkg SHALL hold the state typedef (IDLE=2'b00, COUNT=2'b01, DETECTED=2'b10) and the default parameter constants.
REQ-030 Per-channel logic SHALL be sub-module run_det_chan, instantiated CHANNELS times in a generate loop; illegal state encodings SHALL recover to IDLE.

Verification
REQ-031 CHANNELS=4, RUN_LEN=2, match_val=1, overlap=1, ch0 samples 1,1,1,0 -> det[0] high after the 2nd sample through the 3rd, low after the 0; one det_pulse; hit_cnt[0]=1.
REQ-032 Same settings with overlap=0, ch0 samples 1,1,1,1 -> two det_pulses (after samples 2 and 4); hit_cnt[0]=2.
REQ-033 RUN_LEN=3, ch1 samples 1,1 then in_valid low 5 cycles then 1 -> detection after the 3rd consumed sample; other channels stay 0.
REQ-034 match_val=0, ch2 samples 0,0 -> det[2]=1; then rst mid-run after a single 0 -> outputs 0 immediately, next 0 counts as 1.
REQ-035 clr and in_valid asserted together on a completing sample -> no detection; hit_cnt cleared to 0.
REQ-036 HIT_W=2 with RUN_DET_HITCNT_EN, 5 detections -> hit_cnt saturates at 3; without the macro -> hit_cnt stays 0.

Source files
------------

// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - run detector shared state encoding and default parameters
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNT    = 2'b01,
    DETECTED = 2'b10
  } run_state_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_RUN_LEN  = 2;
  localparam int DEF_HIT_W    = 16;

endpackage

// File: rtl/run_det_chan.sv
// rtl/run_det_chan.sv - single-channel run FSM with optional saturating hit counter
// Hit counter is built only when RUN_DET_HITCNT_EN is defined.
module run_det_chan
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int HIT_W   = DEF_HIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic             bit_i,
  input  logic             match_val_i,
  input  logic             overlap_i,
  output logic             det_o,
  output logic             det_pulse_o,
  output logic [HIT_W-1:0] hit_cnt_o
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_M1  = CNT_W'(RUN_LEN - 1);

  run_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             det_q;
  logic             pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (valid_i) begin
        if (bit_i != match_val_i) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          det_q   <= 1'b0;
        end else begin
          case (state_q)
            IDLE, COUNT: begin
              // >= keeps the counter bounded even if it was ever corrupted
              if (cnt_q >= RUN_M1) begin
                state_q <= DETECTED;
                cnt_q   <= RUN_MAX;
                det_q   <= 1'b1;
                pulse_q <= 1'b1;
              end else begin
                state_q <= COUNT;
                cnt_q   <= cnt_q + CNT_W'(1);
                det_q   <= 1'b0;
              end
            end
            DETECTED: begin
              if (overlap_i) begin
                state_q <= DETECTED;
              end else if (RUN_LEN == 1) begin
                cnt_q   <= CNT_W'(1);
                pulse_q <= 1'b1;
              end else begin
                state_q <= COUNT;
                cnt_q   <= CNT_W'(1);
                det_q   <= 1'b0;
              end
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
              det_q   <= 1'b0;
            end
          endcase
        end
      end else if (!(state_q inside {IDLE, COUNT, DETECTED})) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        det_q   <= 1'b0;
      end
    end
  end

  assign det_o       = det_q;
  assign det_pulse_o = pulse_q;

`ifdef RUN_DET_HITCNT_EN
  logic [HIT_W-1:0] hit_q;

  // Counts one cycle behind the pulse; saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
    end else if (clr_i) begin
      hit_q <= '0;
    end else if (pulse_q && (hit_q != {HIT_W{1'b1}})) begin
      hit_q <= hit_q + HIT_W'(1);
    end
  end

  assign hit_cnt_o = hit_q;
`else
  assign hit_cnt_o = '0;
`endif

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - multi-channel run detector top, one run_det_chan per channel
// Optional per-channel hit counters enabled by RUN_DET_HITCNT_EN.
module run_detector
  import run_det_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int RUN_LEN  = DEF_RUN_LEN,
  parameter int HIT_W    = DEF_HIT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_bit,
  input  logic                      match_val,
  input  logic                      overlap,
  output logic [CHANNELS-1:0]       det,
  output logic [CHANNELS-1:0]       det_pulse,
  output logic [CHANNELS*HIT_W-1:0] hit_cnt
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    run_det_chan #(
      .RUN_LEN(RUN_LEN),
      .HIT_W  (HIT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .valid_i    (in_valid[g]),
      .bit_i      (in_bit[g]),
      .match_val_i(match_val),
      .overlap_i  (overlap),
      .det_o      (det[g]),
      .det_pulse_o(det_pulse[g]),
      .hit_cnt_o  (hit_cnt[g*HIT_W +: HIT_W])
    );
  end

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - scoreboard bench for run_detector (RUN_DET_HITCNT_EN aware)
module tb_run_detector;

`ifdef RUN_DET_HITCNT_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, match_val, overlap;
  logic [3:0] in_valid, in_bit;
  logic [3:0] det_a, pulse_a, det_b, pulse_b, det_c, pulse_c;
  logic [63:0] hit_a, hit_b;
  logic [7:0]  hit_c;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  run_detector #(.CHANNELS(4), .RUN_LEN(2), .HIT_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .match_val(match_val), .overlap(overlap), .det(det_a), .det_pulse(pulse_a), .hit_cnt(hit_a));
  run_detector #(.CHANNELS(4), .RUN_LEN(3), .HIT_W(16)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .match_val(match_val), .overlap(overlap), .det(det_b), .det_pulse(pulse_b), .hit_cnt(hit_b));
  run_detector #(.CHANNELS(4), .RUN_LEN(2), .HIT_W(2)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .match_val(match_val), .overlap(overlap), .det(det_c), .det_pulse(pulse_c), .hit_cnt(hit_c));

  task automatic cyc(input logic [3:0] v, input logic [3:0] b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = '0;
    clr      = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if ({det_a, pulse_a} !== 8'h00) $display("FAIL reset_det_a: got %h want 00", {det_a, pulse_a}); else passed++;
    total++; if (hit_a !== 64'h0) $display("FAIL reset_hit_a: got %h want 0", hit_a); else passed++;
    in_valid = 4'hF; in_bit = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({det_b, pulse_b, det_c, pulse_c} !== 16'h0) $display("FAIL reset_hold: got %h want 0000", {det_b, pulse_b, det_c, pulse_c}); else passed++;
    in_valid = '0; in_bit = '0;
    rst = 1'b0;
  endtask

  task automatic test_overlap;
    logic [7:0] e [4] = '{8'h00, 8'h11, 8'h10, 8'h00};
    logic [3:0] s [4] = '{4'h1, 4'h1, 4'h1, 4'h0};
    logic [7:0] x;
    match_val = 1'b1; overlap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e[i]);
      cyc(4'h1, s[i], 1'b0);
      x = exp_q.pop_front();
      total++; if ({det_a, pulse_a} !== x) $display("FAIL overlap_s%0d: got %h want %h", i, {det_a, pulse_a}, x); else passed++;
    end
    total++; if (hit_a !== {48'h0, (HE ? 16'd1 : 16'd0)}) $display("FAIL overlap_hit: got %h want %0d", hit_a, HE); else passed++;
  endtask

  task automatic test_no_overlap;
    logic [7:0] x;
    cyc(4'h0, 4'h0, 1'b1);
    overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2) ? 8'h11 : 8'h00);
      cyc(4'h1, 4'h1, 1'b0);
      x = exp_q.pop_front();
      total++; if ({det_a, pulse_a} !== x) $display("FAIL nooverlap_s%0d: got %h want %h", i, {det_a, pulse_a}, x); else passed++;
    end
    cyc(4'h0, 4'h0, 1'b0);
    total++; if (hit_a !== {48'h0, (HE ? 16'd2 : 16'd0)}) $display("FAIL nooverlap_hit: got %h want %0d", hit_a, HE ? 2 : 0); else passed++;
    overlap = 1'b1;
  endtask

  task automatic test_gap;
    logic [7:0] x;
    cyc(4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back((i == 7) ? 8'h22 : 8'h00);
      if (i < 2 || i == 7) cyc(4'h2, 4'h2, 1'b0);
      else cyc(4'h0, 4'hF, 1'b0);
      x = exp_q.pop_front();
      total++; if ({det_b, pulse_b} !== x) $display("FAIL gap_c%0d: got %h want %h", i, {det_b, pulse_b}, x); else passed++;
    end
  endtask

  task automatic test_match_zero;
    logic [7:0] x;
    cyc(4'h0, 4'h0, 1'b1);
    match_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back((i == 1) ? 8'h44 : 8'h00);
      cyc(4'h4, 4'h0, 1'b0);
      x = exp_q.pop_front();
      total++; if ({det_a, pulse_a} !== x) $display("FAIL zero_s%0d: got %h want %h", i, {det_a, pulse_a}, x); else passed++;
    end
    rst = 1'b1;
    #2;
    total++; if ({det_a, pulse_a} !== 8'h00) $display("FAIL zero_async_rst: got %h want 00", {det_a, pulse_a}); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.push_back(8'h00);
    cyc(4'h4, 4'h0, 1'b0);
    x = exp_q.pop_front();
    total++; if ({det_a, pulse_a} !== x) $display("FAIL zero_partial: got %h want %h", {det_a, pulse_a}, x); else passed++;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back((i == 1) ? 8'h44 : 8'h00);
      cyc(4'h4, 4'h0, 1'b0);
      x = exp_q.pop_front();
      total++; if ({det_a, pulse_a} !== x) $display("FAIL zero_after_rst%0d: got %h want %h", i, {det_a, pulse_a}, x); else passed++;
    end
    match_val = 1'b1;
  endtask

  task automatic test_clr_priority;
    logic [7:0] e [7] = '{8'h00, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h88};
    logic [3:0] s [7] = '{4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8};
    logic [7:0] x;
    cyc(4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(e[i]);
      cyc(4'h8, s[i], (i == 4));
      x = exp_q.pop_front();
      total++; if ({det_a, pulse_a} !== x) $display("FAIL clr_s%0d: got %h want %h", i, {det_a, pulse_a}, x); else passed++;
      if (i == 4) begin
        total++; if (hit_a !== 64'h0) $display("FAIL clr_hit: got %h want 0", hit_a); else passed++;
      end
    end
  endtask

  task automatic test_saturate;
    logic [7:0] x;
    cyc(4'h0, 4'h0, 1'b1);
    overlap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back((i % 2) ? 8'h11 : 8'h00);
      cyc(4'h1, 4'h1, 1'b0);
      x = exp_q.pop_front();
      total++; if ({det_c, pulse_c} !== x) $display("FAIL sat_s%0d: got %h want %h", i, {det_c, pulse_c}, x); else passed++;
    end
    cyc(4'h0, 4'h0, 1'b0);
    total++; if (hit_c !== (HE ? 8'h03 : 8'h00)) $display("FAIL sat_hit_c: got %h want %h", hit_c, HE ? 3 : 0); else passed++;
    total++; if (hit_a !== {48'h0, (HE ? 16'd5 : 16'd0)}) $display("FAIL sat_hit_a: got %h want %0d", hit_a, HE ? 5 : 0); else passed++;
    overlap = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; match_val = 1'b1; overlap = 1'b1;
    in_valid = '0; in_bit = '0;
    test_reset;
    test_overlap;
    test_no_overlap;
    test_gap;
    test_match_zero;
    test_clr_priority;
    test_saturate;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
